rot_sequencer: RTL and testbench

ROT_SEQUENCER -- requirements
Module: rot_sequencer

---
 rtl/rot_pkg.sv | 26 ++
 rtl/rot_seq_wdog.sv | 34 +++
 rtl/rot_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_rot_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotation sequencer: FSM state encoding,
// DMA command direction constants and a small state-class helper.
// Used by rot_sequencer and, when ROT_SEQ_TIMEOUT_EN is defined,
// by the rot_seq_wdog watchdog.
package rot_pkg;

  // Sequencer states. Each tile is a read burst followed by a write burst.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_FIN     = 3'd5
  } rs_state_e;

  // Direction encoding carried on the command write flag.
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // True while the sequencer waits for a DMA burst to complete.
  function automatic logic is_wait_state(input rs_state_e s);
    return (s == ST_RD_WAIT) || (s == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/rot_seq_wdog.sv
// Cycle watchdog for the sequencer wait states. Counts while run_i is
// high, restarts from zero whenever run_i drops (every wait state is
// entered from a request state, so this restarts it on each entry),
// and flags expiry on the cycle the count reaches TIMEOUT_CYC-1.
// Only instantiated when ROT_SEQ_TIMEOUT_EN is defined.
module rot_seq_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic soft_rst_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count wait cycles, saturating at the limit; cleared outside wait states.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (soft_rst_i || !run_i) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = run_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/rot_sequencer.sv
// Rotation sequencer: walks TILE_TOTAL tiles, issuing a read burst then a
// write burst per tile to the DMA, and reports sticky done status with a
// maskable interrupt. Define ROT_SEQ_TIMEOUT_EN to add the wait-state
// watchdog (rot_seq_wdog) and the sticky O_RS_ERR output.
module rot_sequencer
  import rot_pkg::*;
#(
  parameter int unsigned TILE_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              I_RS_HCLK,
  input  logic              I_RS_HRESET_N,
  input  logic              I_RS_RESET,
  input  logic              I_RS_START,
  input  logic [TILE_W-1:0] I_RS_TILE_TOTAL,
  input  logic              I_RS_INTR_MASK,
  input  logic              I_RS_INTR_CLEAR,
  input  logic              I_RS_CMD_READY,
  input  logic              I_RS_DMA_DONE,
  output logic              O_RS_CMD_VALID,
  output logic              O_RS_CMD_WRITE,
  output logic [TILE_W-1:0] O_RS_TILE_IDX,
  output logic              O_RS_BUSY,
  output logic              O_RS_DONE,
  output logic              O_RS_INTR
`ifdef ROT_SEQ_TIMEOUT_EN
  ,
  output logic              O_RS_ERR
`endif
);

  rs_state_e         state_q;
  logic [TILE_W-1:0] total_q;
  logic [TILE_W-1:0] tile_idx_q;
  logic              start_low_q;   // START was sampled low last cycle
  logic              cmd_valid_q;
  logic              cmd_write_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              start_edge;
  logic              last_tile;
  logic              wd_expired;

  // start_low_q resets to 0, so a START that is already high when reset
  // releases must first be seen low before it can produce an edge.
  assign start_edge = I_RS_START && start_low_q;
  assign last_tile  = (tile_idx_q == (total_q - TILE_W'(1)));

`ifdef ROT_SEQ_TIMEOUT_EN
  rot_seq_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk_i      (I_RS_HCLK),
    .rst_n_i    (I_RS_HRESET_N),
    .soft_rst_i (I_RS_RESET),
    .run_i      (is_wait_state(state_q)),
    .expired_o  (wd_expired)
  );

  assign O_RS_ERR = err_q;
`else
  // Waits are unbounded; the timeout limit has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign wd_expired         = 1'b0;
`endif

  // Sequencer FSM with registered outputs; hard and soft reset both return
  // every register to its idle value.
  // NOTE: all state here uses non-blocking assignments so every register
  // updates from pre-edge values; later assignments in the block take
  // priority, which is how "set wins over clear" is expressed below.
  always_ff @(posedge I_RS_HCLK or negedge I_RS_HRESET_N) begin
    if (!I_RS_HRESET_N) begin
      state_q     <= ST_IDLE;
      total_q     <= '0;
      tile_idx_q  <= '0;
      start_low_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= CMD_READ;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (I_RS_RESET) begin
      state_q     <= ST_IDLE;
      total_q     <= '0;
      tile_idx_q  <= '0;
      start_low_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= CMD_READ;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_low_q <= !I_RS_START;

      // Status clear first; any set in the state logic below overrides it.
      if (I_RS_INTR_CLEAR) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          // Start edges are only acted on here, so edges while busy are lost.
          if (start_edge) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (I_RS_TILE_TOTAL == '0) begin
              state_q <= ST_FIN;
            end else begin
              state_q     <= ST_RD_REQ;
              total_q     <= I_RS_TILE_TOTAL;
              tile_idx_q  <= '0;
              cmd_valid_q <= 1'b1;
              cmd_write_q <= CMD_READ;
            end
          end
        end

        ST_RD_REQ: begin
          if (I_RS_CMD_READY) begin
            state_q     <= ST_RD_WAIT;
            cmd_valid_q <= 1'b0;
          end
        end

        ST_RD_WAIT: begin
          if (I_RS_DMA_DONE) begin
            state_q     <= ST_WR_REQ;
            cmd_valid_q <= 1'b1;
            cmd_write_q <= CMD_WRITE;
          end else if (wd_expired) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end

        ST_WR_REQ: begin
          if (I_RS_CMD_READY) begin
            state_q     <= ST_WR_WAIT;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= CMD_READ;
          end
        end

        ST_WR_WAIT: begin
          if (I_RS_DMA_DONE) begin
            if (last_tile) begin
              state_q <= ST_FIN;
            end else begin
              state_q     <= ST_RD_REQ;
              tile_idx_q  <= tile_idx_q + TILE_W'(1);
              cmd_valid_q <= 1'b1;
              cmd_write_q <= CMD_READ;
            end
          end else if (wd_expired) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end

        ST_FIN: begin
          // DONE is set as FIN retires, winning over a clear in this cycle.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          cmd_valid_q <= 1'b0;
          cmd_write_q <= CMD_READ;
        end
      endcase
    end
  end

  assign O_RS_CMD_VALID = cmd_valid_q;
  assign O_RS_CMD_WRITE = cmd_write_q;
  assign O_RS_TILE_IDX  = tile_idx_q;
  assign O_RS_BUSY      = busy_q;
  assign O_RS_DONE      = done_q;
  assign O_RS_INTR      = (done_q || err_q) && !I_RS_INTR_MASK;

endmodule

// File: tb/tb_rot_sequencer.sv
// Directed bench for rot_sequencer. Inputs change 1 ns after the rising
// edge and outputs are sampled there too. A small DMA responder (svc_tick)
// logs each command handshake and pulses DMA_DONE so that every wait state
// lasts two cycles. Watchdog steps run when ROT_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_rot_sequencer;

  localparam int TILE_W      = 16;
  localparam int TIMEOUT_CYC = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              soft_rst;
  logic              start;
  logic [TILE_W-1:0] total;
  logic              mask;
  logic              clear;
  logic              ready;
  logic              dma_done;
  logic              cmd_valid;
  logic              cmd_write;
  logic [TILE_W-1:0] tile_idx;
  logic              busy;
  logic              done;
  logic              intr;
`ifdef ROT_SEQ_TIMEOUT_EN
  logic              err;
`endif

  int errors = 0;
  int checks = 0;

  // DMA responder state
  int                cd     = 0;   // cycles until the DMA_DONE pulse
  int                hs_n   = 0;   // handshakes seen
  int                busy_n = 0;   // busy cycles seen
  int                dd_n   = 0;   // DMA_DONE pulses driven
  logic              hs_wr  [16];
  logic [TILE_W-1:0] hs_idx [16];

  always #5 clk = ~clk;

  rot_sequencer #(
    .TILE_W      (TILE_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .I_RS_HCLK       (clk),
    .I_RS_HRESET_N   (rst_n),
    .I_RS_RESET      (soft_rst),
    .I_RS_START      (start),
    .I_RS_TILE_TOTAL (total),
    .I_RS_INTR_MASK  (mask),
    .I_RS_INTR_CLEAR (clear),
    .I_RS_CMD_READY  (ready),
    .I_RS_DMA_DONE   (dma_done),
    .O_RS_CMD_VALID  (cmd_valid),
    .O_RS_CMD_WRITE  (cmd_write),
    .O_RS_TILE_IDX   (tile_idx),
    .O_RS_BUSY       (busy),
    .O_RS_DONE       (done),
    .O_RS_INTR       (intr)
`ifdef ROT_SEQ_TIMEOUT_EN
    ,
    .O_RS_ERR        (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the DMA responder active: a handshake at the coming edge
  // is logged, and DMA_DONE is driven in the second wait cycle after it.
  task automatic svc_tick();
    if (cmd_valid && ready) begin
      if (hs_n < 16) begin
        hs_wr[hs_n]  = cmd_write;
        hs_idx[hs_n] = tile_idx;
      end
      hs_n++;
      cd = 2;
    end
    @(posedge clk);
    #1;
    dma_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        dma_done = 1'b1;
        dd_n++;
      end
    end
    if (busy) busy_n++;
  endtask

  initial begin
    int ok_n;
    logic [15:0] seq;

    rst_n    = 1'b0;
    soft_rst = 1'b0;
    start    = 1'b1;   // high across reset release: must not start a run
    total    = '0;
    mask     = 1'b0;
    clear    = 1'b0;
    ready    = 1'b0;
    dma_done = 1'b0;

    // ---- hard reset ----
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {27'd0, cmd_valid, cmd_write, busy, done, intr}, 32'd0);
    check("reset_idx", {16'd0, tile_idx}, 32'd0);
`ifdef ROT_SEQ_TIMEOUT_EN
    check("reset_err", {31'd0, err}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("start_high_at_release", {31'd0, busy}, 32'd0);
    start = 1'b0;
    tick();

    // ---- two tiles, READY tied high ----
    ready = 1'b1; total = 16'd2; hs_n = 0; busy_n = 0; dd_n = 0; cd = 0;
    start = 1'b1;
    svc_tick();
    start = 1'b0;
    for (int i = 0; i < 40 && dd_n < 4; i++) svc_tick();
    check("run2_done_pulses", dd_n, 32'd4);
    svc_tick();   // FIN cycle
    check("run2_fin", {29'd0, busy, cmd_valid, done}, 32'b100);
    svc_tick();
    check("run2_done", {29'd0, busy, done, intr}, 32'b011);
    check("run2_busy_cycles", busy_n, 32'd13);
    check("run2_hs_count", hs_n, 32'd4);
    seq = {hs_wr[0], hs_idx[0][2:0], hs_wr[1], hs_idx[1][2:0],
           hs_wr[2], hs_idx[2][2:0], hs_wr[3], hs_idx[3][2:0]};
    check("run2_cmd_seq_R0W0R1W1", {16'd0, seq}, 32'h0819);
    check("run2_idx_hold", {16'd0, tile_idx}, 32'd1);

    // ---- READY held low for 5 cycles in RD_REQ ----
    ready = 1'b0; total = 16'd1; hs_n = 0;
    start = 1'b1;
    svc_tick();
    start = 1'b0;
    check("stall_done_cleared", {31'd0, done}, 32'd0);
    ok_n = 0;
    for (int k = 0; k < 5; k++) begin
      if (cmd_valid === 1'b1 && cmd_write === 1'b0) ok_n++;
      svc_tick();
    end
    ready = 1'b1;
    if (cmd_valid === 1'b1 && cmd_write === 1'b0) ok_n++;
    check("stall_valid_read_6cyc", ok_n, 32'd6);
    svc_tick();
    check("stall_one_handshake", {hs_n[30:0], cmd_valid}, {31'd1, 1'b0});
    for (int i = 0; i < 40 && busy; i++) svc_tick();
    check("stall_run_end", {29'd0, busy, done, hs_n == 2}, 32'b011);

    // ---- zero tiles, mask and clear ----
    total = '0; mask = 1'b1; hs_n = 0;
    start = 1'b1;
    svc_tick();
    start = 1'b0;
    check("zero_fin", {29'd0, busy, cmd_valid, done}, 32'b100);
    svc_tick();
    check("zero_done_masked", {29'd0, busy, done, intr}, 32'b010);
    mask = 1'b0;
    #1;
    check("zero_intr_unmasked", {31'd0, intr}, 32'd1);
    clear = 1'b1;
    svc_tick();
    clear = 1'b0;
    check("zero_clear", {29'd0, done, intr, hs_n == 0}, 32'b001);

    // ---- soft reset in WR_WAIT of tile 3 ----
    total = 16'd5; ready = 1'b1; hs_n = 0;
    start = 1'b1;
    svc_tick();
    start = 1'b0;
    for (int i = 0; i < 100 && hs_n < 8; i++) svc_tick();
    check("srst_at_wr_wait_t3", {15'd0, tile_idx, busy, cmd_valid}, {15'd0, 16'd3, 1'b1, 1'b0});
    soft_rst = 1'b1; cd = 0;
    svc_tick();
    soft_rst = 1'b0;
    check("srst_outs", {11'd0, cmd_valid, cmd_write, busy, done, intr, tile_idx}, 32'd0);
    dma_done = 1'b1;   // stray burst completion
    svc_tick();
    svc_tick();
    check("srst_stray_done", {11'd0, cmd_valid, cmd_write, busy, done, intr, tile_idx}, 32'd0);

    // ---- second START mid-run, CLEAR in the FIN cycle ----
    total = 16'd1; ready = 1'b1; hs_n = 0; dd_n = 0;
    start = 1'b1;
    svc_tick();
    start = 1'b0;
    svc_tick();
    start = 1'b1;      // edge while busy
    svc_tick();
    start = 1'b0;
    for (int i = 0; i < 40 && dd_n < 2; i++) svc_tick();
    svc_tick();        // FIN cycle
    clear = 1'b1;
    check("restart_fin", {30'd0, busy, cmd_valid}, 32'b10);
    svc_tick();
    clear = 1'b0;
    check("restart_set_wins", {30'd0, busy, done}, 32'b01);
    repeat (4) svc_tick();
    check("restart_not_remembered", {busy_n[0] & 1'b0, 30'd0, busy} | {27'd0, hs_n[4:0]}, 32'd2);

`ifdef ROT_SEQ_TIMEOUT_EN
    // ---- watchdog: DMA_DONE withheld ----
    total = 16'd1; ready = 1'b1; cd = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wd_rd_req", {31'd0, cmd_valid}, 32'd1);
    ok_n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy === 1'b1 && err === 1'b0) ok_n++;
    end
    check("wd_wait_busy", ok_n, 32'd8);
    tick();
    check("wd_expired", {28'd0, err, intr, busy, done}, 32'b1100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("wd_err_clear", {30'd0, err, intr}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
